// File: rtl/comparador_serial_uc.sv
// Serial multi-word unsigned magnitude comparator: one WORD_W compare per clock.
// Optional MSW-first early-exit scan when COMPARADOR_SERIAL_EARLY_EXIT_EN is defined.
module comparador_serial_uc #(
  parameter  int unsigned WORD_W  = 6,
  parameter  int unsigned N_WORDS = 4,
  localparam int unsigned IDX_W   = $clog2(N_WORDS),
  localparam int unsigned OP_W    = N_WORDS * WORD_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic [OP_W-1:0]  A,
  input  logic [OP_W-1:0]  B,
  output logic             ocupado,
  output logic             pronto,
  output logic             menor,
  output logic             maior,
  output logic             igual,
  output logic [IDX_W-1:0] indice
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
`ifdef COMPARADOR_SERIAL_EARLY_EXIT_EN
  localparam logic [IDX_W-1:0] START_IDX = LAST_IDX;
`else
  localparam logic [IDX_W-1:0] START_IDX = '0;
`endif

  typedef enum logic [1:0] {ESPERA, COMPARA, FIM} state_t;

  state_t           state_q, state_d;
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0] idx_d;
  logic             eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic             menor_d, maior_d, igual_d, ocupado_d, pronto_d;
  logic [WORD_W-1:0] a_w, b_w;
  logic             w_lt, w_gt, nlt, ngt, neq;

  // Current word and the partial result after folding it in
  assign a_w  = a_q[int'(indice)*WORD_W +: WORD_W];
  assign b_w  = b_q[int'(indice)*WORD_W +: WORD_W];
  assign w_lt = (a_w < b_w);
  assign w_gt = (a_w > b_w);
  assign nlt  = w_lt | (lt_q & ~w_gt);
  assign ngt  = w_gt | (gt_q & ~w_lt);
  assign neq  = eq_q & ~w_lt & ~w_gt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ESPERA;
      a_q     <= '0;
      b_q     <= '0;
      indice  <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      menor   <= 1'b0;
      maior   <= 1'b0;
      igual   <= 1'b0;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      indice  <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      menor   <= menor_d;
      maior   <= maior_d;
      igual   <= igual_d;
      ocupado <= ocupado_d;
      pronto  <= pronto_d;
    end
  end

  // Next state; outputs are computed one cycle ahead and registered
  always_comb begin
    logic done;
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = indice;
    eq_d      = eq_q;
    lt_d      = lt_q;
    gt_d      = gt_q;
    menor_d   = menor;
    maior_d   = maior;
    igual_d   = igual;
    ocupado_d = 1'b0;
    pronto_d  = 1'b0;
    done      = 1'b0;
    case (state_q)
      ESPERA: begin
        if (iniciar) begin
          a_d       = A;
          b_d       = B;
          eq_d      = 1'b1;
          lt_d      = 1'b0;
          gt_d      = 1'b0;
          menor_d   = 1'b0;
          maior_d   = 1'b0;
          igual_d   = 1'b0;
          idx_d     = START_IDX;
          ocupado_d = 1'b1;
          state_d   = COMPARA;
        end
      end
      COMPARA: begin
        ocupado_d = 1'b1;
        eq_d      = neq;
        lt_d      = nlt;
        gt_d      = ngt;
`ifdef COMPARADOR_SERIAL_EARLY_EXIT_EN
        if (w_lt || w_gt || (indice == '0)) done = 1'b1;
        else                                 idx_d = indice - IDX_W'(1);
`else
        if (indice == LAST_IDX) done = 1'b1;
        else                    idx_d = indice + IDX_W'(1);
`endif
        if (done) begin
          ocupado_d = 1'b0;
          menor_d   = nlt;
          maior_d   = ngt;
          igual_d   = neq;
          state_d   = FIM;
        end
      end
      FIM: begin
        pronto_d = 1'b1;
        state_d  = ESPERA;
      end
      default: state_d = ESPERA;
    endcase
  end

endmodule

// File: tb/tb_comparador_serial_uc.sv
// Scoreboard bench for comparador_serial_uc (WORD_W=6, N_WORDS=4).
module tb_comparador_serial_uc;
  localparam int unsigned WORD_W  = 6;
  localparam int unsigned N_WORDS = 4;
`ifdef COMPARADOR_SERIAL_EARLY_EXIT_EN
  localparam int LAT_MSW = 2;
`else
  localparam int LAT_MSW = 5;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic [23:0] A = '0;
  logic [23:0] B = '0;
  logic        ocupado, pronto, menor, maior, igual;
  logic [1:0]  indice;

  comparador_serial_uc #(.WORD_W(WORD_W), .N_WORDS(N_WORDS)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .A(A), .B(B),
    .ocupado(ocupado), .pronto(pronto), .menor(menor), .maior(maior),
    .igual(igual), .indice(indice)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic  menor;
    logic  maior;
    logic  igual;
    int    start;
    int    lat;
    string name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pronto pulse must match the oldest pending expectation
  always @(negedge clock) begin
    exp_t e;
    if (pronto === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pronto: pronto=1 with nothing pending (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_flags"}, 32'({menor, maior, igual}), 32'({e.menor, e.maior, e.igual}));
        chk({e.name, "_latency"}, 32'(cyc - e.start), 32'(e.lat));
      end
    end
  end

  task automatic start_op(input logic [23:0] a, input logic [23:0] b, input logic m,
                          input logic x, input logic i, input int lat, input string name,
                          input bit hold);
    exp_t e;
    @(negedge clock);
    A = a; B = b; iniciar = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) iniciar = 1'b0;
    e = '{m, x, i, cyc, lat, name};
    sb.push_back(e);
    chk({name, "_cleared"}, 32'({menor, maior, igual}), 32'(0));
  endtask

  task automatic wait_done(input string name, output int ocnt);
    ocnt = 0;
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      @(negedge clock);
      #1;
      if (ocupado) ocnt++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d results still pending", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [23:0] a, input logic [23:0] b, input logic m,
                     input logic x, input logic i, input int lat, input string name);
    int oc;
    start_op(a, b, m, x, i, lat, name, 1'b0);
    wait_done(name, oc);
    @(negedge clock);
    #1;
    chk({name, "_held"}, 32'({menor, maior, igual}), 32'({m, x, i}));
  endtask

  initial begin
    int oc;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", 32'({ocupado, pronto, menor, maior, igual}), 32'(0));
    chk("reset_indice", 32'(indice), 32'(0));
    @(negedge clock) reset = 1'b1;

    // Equal operands, with busy-length check
    start_op(24'hABCDEF, 24'hABCDEF, 1'b0, 1'b0, 1'b1, 5, "equal", 1'b0);
    wait_done("equal", oc);
    chk("equal_ocupado_cycles", 32'(oc), 32'(4));

    run(24'h100000, 24'h0FFFFF, 1'b0, 1'b1, 1'b0, LAT_MSW, "msw_greater");
    run(24'h000001, 24'h000002, 1'b1, 1'b0, 1'b0, 5, "lsw_less");
    run(24'hFC0000, 24'h000000, 1'b0, 1'b1, 1'b0, LAT_MSW, "msw_max");

    // Restart attempt while busy is ignored, operand changes too
    start_op(24'h000010, 24'h000020, 1'b1, 1'b0, 1'b0, 5, "ignore_restart", 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    A = 24'hFFFFFF; B = 24'h000000; iniciar = 1'b1;
    @(posedge clock);
    #1 iniciar = 1'b0;
    wait_done("ignore_restart", oc);

    // Abort by reset in the middle of a comparison
    @(negedge clock);
    A = 24'h123456; B = 24'h654321; iniciar = 1'b1;
    @(posedge clock);
    #1 iniciar = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("abort_busy_before", 32'(ocupado), 32'(1));
    reset = 1'b0;
    #1;
    chk("abort_outputs", 32'({ocupado, pronto, menor, maior, igual}), 32'(0));
    chk("abort_indice", 32'(indice), 32'(0));
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    run(24'h000000, 24'h000000, 1'b0, 1'b0, 1'b1, 5, "after_abort");

    // iniciar held high: two back-to-back comparisons with one idle cycle
    start_op(24'h000003, 24'h000003, 1'b0, 1'b0, 1'b1, 5, "b2b_first", 1'b1);
    begin
      exp_t e2;
      e2 = '{1'b0, 1'b0, 1'b1, cyc + 6, 5, "b2b_second"};
      sb.push_back(e2);
    end
    repeat (6) @(posedge clock);
    #1 iniciar = 1'b0;
    wait_done("b2b", oc);
    repeat (4) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
